// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port-per-direction Ram between
// instruction fetch (m0) and load/store (m1); partial stores become read-modify-write.
module ram_arbiter #(
    parameter int MEM_WIDTH  = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_we,
    input  logic [MEM_WIDTH-1:0]  m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic                  m0_resp_valid,
    output logic [MEM_WIDTH-1:0]  m0_rdata,
    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_we,
    input  logic [MEM_WIDTH-1:0]  m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic                  m1_resp_valid,
    output logic [MEM_WIDTH-1:0]  m1_rdata,
    output logic                  ram_wen,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [MEM_WIDTH-1:0]  ram_wdata,
    input  logic [MEM_WIDTH-1:0]  ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        RMW_WR,
        WR_ACK
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [MEM_WIDTH-1:0]  r_wdata;
    logic [3:0]            r_wstrb;

    logic                  w_any;
    logic                  w_grant1;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [MEM_WIDTH-1:0]  w_wdata;
    logic [3:0]            w_wstrb;
    logic                  w_full;
    logic                  w_none;
    logic [MEM_WIDTH-1:0]  w_merge;

    // Under contention the requester that did not win last time goes next
    assign w_any    = m0_req_valid | m1_req_valid;
    assign w_grant1 = m1_req_valid & (~m0_req_valid | ~r_last);
    assign w_we     = w_grant1 ? m1_we    : m0_we;
    assign w_addr   = w_grant1 ? m1_addr  : m0_addr;
    assign w_wdata  = w_grant1 ? m1_wdata : m0_wdata;
    assign w_wstrb  = w_grant1 ? m1_wstrb : m0_wstrb;
    assign w_full   = (w_wstrb == 4'hF);
    assign w_none   = (w_wstrb == 4'h0);

    always_comb begin
        w_merge = '0;
        for (int i = 0; i < 4; i++) begin
            w_merge[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8]
                                           : ram_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_grant1;
                        r_last  <= w_grant1;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_wstrb <= w_wstrb;
                        if (!w_we)
                            r_state <= RD_DATA;
                        else if (w_full || w_none)
                            r_state <= WR_ACK;
                        else
                            r_state <= RMW_WR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Everything is forced low while rst is high, so a dropped RMW never writes
    always_comb begin
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        m0_rdata      = '0;
        m1_rdata      = '0;
        ram_wen       = 1'b0;
        ram_ren       = 1'b0;
        ram_waddr     = '0;
        ram_raddr     = '0;
        ram_wdata     = '0;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        m0_req_ready = ~w_grant1;
                        m1_req_ready = w_grant1;
                        if (!w_we || !(w_full || w_none)) begin
                            ram_ren   = 1'b1;
                            ram_raddr = w_addr;
                        end else if (w_full) begin
                            ram_wen   = 1'b1;
                            ram_waddr = w_addr;
                            ram_wdata = w_wdata;
                        end
                    end
                end
                RD_DATA: begin
                    m0_resp_valid = ~r_id;
                    m1_resp_valid = r_id;
                    if (r_id) m1_rdata = ram_rdata;
                    else      m0_rdata = ram_rdata;
                end
                RMW_WR: begin
                    ram_wen       = 1'b1;
                    ram_waddr     = r_addr;
                    ram_wdata     = w_merge;
                    m0_resp_valid = ~r_id;
                    m1_resp_valid = r_id;
                end
                WR_ACK: begin
                    m0_resp_valid = ~r_id;
                    m1_resp_valid = r_id;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: Ram model plus a memory-level
// reference with round-robin grant prediction.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  p_valid;
    logic        p_we    [2];
    logic [7:0]  p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_wstrb [2];

    logic        m0_req_ready, m1_req_ready;
    logic        m0_resp_valid, m1_resp_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_wen, ram_ren;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];
    logic        tb_last;
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (p_valid[0]),
        .m0_req_ready  (m0_req_ready),
        .m0_addr       (p_addr[0]),
        .m0_we         (p_we[0]),
        .m0_wdata      (p_wdata[0]),
        .m0_wstrb      (p_wstrb[0]),
        .m0_resp_valid (m0_resp_valid),
        .m0_rdata      (m0_rdata),
        .m1_req_valid  (p_valid[1]),
        .m1_req_ready  (m1_req_ready),
        .m1_addr       (p_addr[1]),
        .m1_we         (p_we[1]),
        .m1_wdata      (p_wdata[1]),
        .m1_wstrb      (p_wstrb[1]),
        .m1_resp_valid (m1_resp_valid),
        .m1_rdata      (m1_rdata),
        .ram_wen       (ram_wen),
        .ram_ren       (ram_ren),
        .ram_waddr     (ram_waddr),
        .ram_raddr     (ram_raddr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    end

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (nw & m) | (old & ~m);
    endfunction

    function automatic logic [117:0] all_out();
        return {m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid,
                m0_rdata, m1_rdata, ram_wen, ram_ren,
                ram_waddr, ram_raddr, ram_wdata};
    endfunction

    task automatic set_req(input int id, input logic we, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        p_we[id] = we; p_addr[id] = a; p_wdata[id] = d; p_wstrb[id] = s;
    endtask

    // One full transaction: accept cycle, then response cycle
    task automatic txn(input bit v0, input bit v1, input bit hold);
        bit          w;
        logic        we, e_ren, e_wen, rmw;
        logic [7:0]  a, e_ra, e_wa;
        logic [31:0] d, e_wd, e_rd, got_rd, other_rd;
        logic [3:0]  s;
        w  = (v0 && v1) ? ~tb_last : v1;
        p_valid = {v1, v0};
        we = p_we[w]; a = p_addr[w]; d = p_wdata[w]; s = p_wstrb[w];
        e_ren = !we || (s != 4'hF && s != 4'h0);
        e_wen = we && (s == 4'hF);
        e_ra  = e_ren ? a : 8'h0;
        e_wa  = e_wen ? a : 8'h0;
        e_wd  = e_wen ? d : 32'h0;
        @(negedge clk);
        checks++;
        if ({m1_req_ready, m0_req_ready} !== (w ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL grant: got %b want %b",
                     {m1_req_ready, m0_req_ready}, (w ? 2'b10 : 2'b01));
        end
        checks++;
        if ({ram_ren, ram_wen, ram_raddr, ram_waddr, ram_wdata}
            !== {e_ren, e_wen, e_ra, e_wa, e_wd}) begin
            errors++;
            $display("FAIL ram_accept: got ren=%b wen=%b ra=%h wa=%h wd=%h want %b %b %h %h %h",
                     ram_ren, ram_wen, ram_raddr, ram_waddr, ram_wdata,
                     e_ren, e_wen, e_ra, e_wa, e_wd);
        end
        checks++;
        if ({m1_resp_valid, m0_resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL early_resp: got %b want 00",
                     {m1_resp_valid, m0_resp_valid});
        end
        @(posedge clk); #1;
        tb_last = w;
        if (!hold) p_valid = 2'b00;
        rmw  = we && (s != 4'hF) && (s != 4'h0);
        e_rd = we ? 32'h0 : ref_mem[a];
        e_wd = rmw ? merge(ref_mem[a], d, s) : 32'h0;
        e_wa = rmw ? a : 8'h0;
        @(negedge clk);
        got_rd   = w ? m1_rdata : m0_rdata;
        other_rd = w ? m0_rdata : m1_rdata;
        last_rd  = got_rd;
        checks++;
        if ({m1_req_ready, m0_req_ready, m1_resp_valid, m0_resp_valid}
            !== {2'b00, (w ? 2'b10 : 2'b01)}) begin
            errors++;
            $display("FAIL resp: got rdy=%b resp=%b want rdy=00 resp=%b",
                     {m1_req_ready, m0_req_ready},
                     {m1_resp_valid, m0_resp_valid}, (w ? 2'b10 : 2'b01));
        end
        checks++;
        if (got_rd !== e_rd || other_rd !== 32'h0) begin
            errors++;
            $display("FAIL rdata: m%0d got %h want %h (other %h want 0)",
                     w, got_rd, e_rd, other_rd);
        end
        checks++;
        if ({ram_ren, ram_wen, ram_waddr, ram_raddr, ram_wdata}
            !== {1'b0, rmw, e_wa, 8'h0, e_wd}) begin
            errors++;
            $display("FAIL ram_resp: got ren=%b wen=%b wa=%h ra=%h wd=%h want 0 %b %h 00 %h",
                     ram_ren, ram_wen, ram_waddr, ram_raddr, ram_wdata,
                     rmw, e_wa, e_wd);
        end
        if (we && s != 4'h0) ref_mem[a] = merge(ref_mem[a], d, s);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p_valid = 2'b11;
        set_req(0, 1'b0, 8'h12, $urandom, 4'hF);
        set_req(1, 1'b1, 8'h34, $urandom, 4'hF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (all_out() !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 0", all_out());
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        p_valid = 2'b00;
        tb_last = 1'b1;
    endtask

    task automatic test_full_write_read();
        set_req(1, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        txn(1'b0, 1'b1, 1'b0);
        set_req(0, 1'b0, 8'd5, 32'h0, 4'h0);
        txn(1'b1, 1'b0, 1'b0);
        checks++;
        if (last_rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL readback_full: got %h want deadbeef", last_rd);
        end
    endtask

    task automatic test_rmw();
        set_req(1, 1'b1, 8'd5, 32'h000000AA, 4'b0001);
        txn(1'b0, 1'b1, 1'b0);
        set_req(0, 1'b0, 8'd5, 32'h0, 4'h0);
        txn(1'b1, 1'b0, 1'b0);
        checks++;
        if (last_rd !== 32'hDEADBEAA) begin
            errors++;
            $display("FAIL readback_rmw: got %h want deadbeaa", last_rd);
        end
    endtask

    task automatic test_contention();
        test_reset();
        set_req(0, 1'b0, 8'($urandom_range(0, 255)), 32'h0, 4'h0);
        set_req(1, 1'b0, 8'($urandom_range(0, 255)), 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) txn(1'b1, 1'b1, 1'b1);
        p_valid = 2'b00;
    endtask

    task automatic test_reset_mid_rmw();
        set_req(1, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        txn(1'b0, 1'b1, 1'b0);
        set_req(1, 1'b1, 8'd5, 32'h000000AA, 4'b0001);
        p_valid = 2'b10;
        @(negedge clk);
        checks++;
        if ({m1_req_ready, ram_ren, ram_wen} !== 3'b110) begin
            errors++;
            $display("FAIL mid_accept: got rdy/ren/wen %b want 110",
                     {m1_req_ready, ram_ren, ram_wen});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (all_out() !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h want 0", all_out());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        p_valid = 2'b00;
        tb_last = 1'b1;
        checks++;
        if (ram_mem[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mid_mem: got %h want deadbeef", ram_mem[5]);
        end
        set_req(0, 1'b0, 8'd5, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'd5, 32'h0, 4'h0);
        txn(1'b1, 1'b1, 1'b0);
        checks++;
        if (last_rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mid_readback: got %h want deadbeef", last_rd);
        end
    endtask

    task automatic test_zero_strobe();
        set_req(0, 1'b1, 8'd9, $urandom, 4'h0);
        txn(1'b1, 1'b0, 1'b0);
        set_req(0, 1'b0, 8'd9, 32'h0, 4'h0);
        txn(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b0, 8'(i), 32'h0, 4'h0);
            txn(1'b1, 1'b0, 1'b1);
        end
        p_valid = 2'b00;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int v;
            v = $urandom_range(1, 3);
            for (int id = 0; id < 2; id++) begin
                logic [3:0] s;
                case ($urandom_range(0, 3))
                    0:       s = 4'hF;
                    1:       s = 4'h0;
                    default: s = 4'($urandom);
                endcase
                set_req(id, 1'($urandom), 8'($urandom_range(0, 15)),
                        $urandom, s);
            end
            txn(v[0], v[1], 1'($urandom));
        end
        p_valid = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            ref_mem[i] = ram_mem[i];
        end
        ram_rdata = '0;
        last_rd = '0;
        tb_last = 1'b1;
        p_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_full_write_read();
        test_rmw();
        test_contention();
        test_reset_mid_rmw();
        test_zero_strobe();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
